// File: rtl/cpu1_mem_copier_pkg.sv
// Shared constants and types for the CPU1 on-chip RAM copy/fill engine.
package cpu1_mem_pkg;
  localparam int CPU1_MEM_ADDR_W = 15;
  localparam int CPU1_MEM_DATA_W = 32;
  localparam int CPU1_MEM_LEN_W  = 16;
  localparam int CPU1_MEM_DEPTH  = 32768;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } cpu1_mem_state_e;

  typedef struct packed {
    logic                       fill;
    logic [CPU1_MEM_ADDR_W-1:0] src;
    logic [CPU1_MEM_ADDR_W-1:0] dst;
    logic [CPU1_MEM_LEN_W-1:0]  len;
    logic [CPU1_MEM_DATA_W-1:0] pattern;
  } cpu1_mem_cmd_t;
endpackage

// File: rtl/cpu1_mem_copier_cmd_reg.sv
// Command latch for the copier: clamps the length, then walks the source and
// destination pointers and the remaining-word counter one word per step.
module cpu1_mem_copier_cmd_reg
  import cpu1_mem_pkg::*;
#(
  parameter int ADDR_W = CPU1_MEM_ADDR_W,
  parameter int DATA_W = CPU1_MEM_DATA_W,
  parameter int LEN_W  = CPU1_MEM_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_fill,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [DATA_W-1:0] i_pattern,
  output logic              o_len_zero,
  output logic              o_fill,
  output logic [ADDR_W-1:0] o_src_ptr,
  output logic [ADDR_W-1:0] o_dst_ptr,
  output logic [DATA_W-1:0] o_pattern,
  output logic              o_last
);
  localparam int unsigned    DEPTH   = 1 << ADDR_W;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_rem;
  logic              r_fill;
  logic [DATA_W-1:0] r_pattern;
  logic [LEN_W-1:0]  w_len_clamped;

  // Longer requests than the RAM depth collapse to one full sweep.
  assign w_len_clamped = (i_len > MAX_LEN) ? MAX_LEN : i_len;
  assign o_len_zero    = (i_len == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_rem     <= '0;
      r_fill    <= 1'b0;
      r_pattern <= '0;
    end else if (i_load) begin
      r_src     <= i_src;
      r_dst     <= i_dst;
      r_rem     <= w_len_clamped;
      r_fill    <= i_fill;
      r_pattern <= i_pattern;
    end else if (i_step) begin
      r_src <= r_src + ADDR_W'(1);
      r_dst <= r_dst + ADDR_W'(1);
      r_rem <= r_rem - LEN_W'(1);
    end
  end

  assign o_fill    = r_fill;
  assign o_src_ptr = r_src;
  assign o_dst_ptr = r_dst;
  assign o_pattern = r_pattern;
  assign o_last    = (r_rem == LEN_W'(1));
endmodule

// File: rtl/cpu1_mem_copier.sv
// CPU1 RAM block copy/fill master (IDLE -> RD/WR -> DONE).
// Optional CPU1_MEM_COPIER_CHECKSUM_EN adds a running sum of written words.
// Handshake: a command is taken on a clock edge where cmd_valid & cmd_ready;
// cmd_ready is high only in IDLE and only while stall is low.
module cpu1_mem_copier
  import cpu1_mem_pkg::*;
#(
  parameter int ADDR_W = CPU1_MEM_ADDR_W,
  parameter int DATA_W = CPU1_MEM_DATA_W,
  parameter int LEN_W  = CPU1_MEM_LEN_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_fill,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [DATA_W-1:0]   cmd_pattern,
  input  logic                stall,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic                clken,
  input  logic [DATA_W-1:0]   readdata,
  output cpu1_mem_state_e     o_dbg_state
`ifdef CPU1_MEM_COPIER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);
  cpu1_mem_state_e   r_state;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_cs;
  logic              r_we;
  logic              w_accept;
  logic              w_step;
  logic              w_len_zero;
  logic              w_fill;
  logic              w_last;
  logic [ADDR_W-1:0] w_src_ptr;
  logic [ADDR_W-1:0] w_dst_ptr;
  logic [DATA_W-1:0] w_pattern;

  assign cmd_ready = r_ready & ~stall;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_step    = (r_state == ST_WR) & ~stall;

  cpu1_mem_copier_cmd_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_cmd_reg (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_step     (w_step),
    .i_fill     (cmd_fill),
    .i_src      (cmd_src),
    .i_dst      (cmd_dst),
    .i_len      (cmd_len),
    .i_pattern  (cmd_pattern),
    .o_len_zero (w_len_zero),
    .o_fill     (w_fill),
    .o_src_ptr  (w_src_ptr),
    .o_dst_ptr  (w_dst_ptr),
    .o_pattern  (w_pattern),
    .o_last     (w_last)
  );

  // Control outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cs    <= 1'b0;
      r_we    <= 1'b0;
    end else if (!stall) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (w_len_zero) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (cmd_fill) begin
              r_state <= ST_WR;
              r_cs    <= 1'b1;
              r_we    <= 1'b1;
            end else begin
              r_state <= ST_RD;
              r_cs    <= 1'b1;
              r_we    <= 1'b0;
            end
          end
        end
        ST_RD: begin
          r_state <= ST_WR;
          r_we    <= 1'b1;
        end
        ST_WR: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_cs    <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
          end else if (!w_fill) begin
            r_state <= ST_RD;
            r_we    <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Copy data comes straight from the RAM: readdata is valid in the WR cycle.
  assign writedata   = r_we ? (w_fill ? w_pattern : readdata) : '0;
  assign address     = r_cs ? (r_we ? w_dst_ptr : w_src_ptr) : '0;
  assign chipselect  = r_cs;
  assign write       = r_we;
  assign byteenable  = {(DATA_W/8){r_cs}};
  assign busy        = r_busy;
  assign done        = r_done;
  assign clken       = ~stall;
  assign o_dbg_state = r_state;

`ifdef CPU1_MEM_COPIER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (w_step) begin
      r_checksum <= r_checksum + writedata;
    end
  end

  assign checksum = r_checksum;
`endif
endmodule

// File: tb/tb_cpu1_mem_copier.sv
// Bench for cpu1_mem_copier: RAM model, directed and random copy/fill
// commands, and a scoreboard of expected memory traffic.
module tb_cpu1_mem_copier;
  import cpu1_mem_pkg::*;

  localparam int AW    = 15;
  localparam int DW    = 32;
  localparam int LW    = 16;
  localparam int DEPTH = 32768;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_fill = 1'b0;
  logic [AW-1:0] cmd_src = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_pattern = '0;
  logic          stall = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect;
  logic          write;
  logic [DW-1:0] writedata;
  logic          clken;
  logic [DW-1:0] readdata;
  cpu1_mem_state_e dbg_state;
`ifdef CPU1_MEM_COPIER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  cpu1_mem_copier dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_fill    (cmd_fill),
    .cmd_src     (cmd_src),
    .cmd_dst     (cmd_dst),
    .cmd_len     (cmd_len),
    .cmd_pattern (cmd_pattern),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .address     (address),
    .byteenable  (byteenable),
    .chipselect  (chipselect),
    .write       (write),
    .writedata   (writedata),
    .clken       (clken),
    .readdata    (readdata),
    .o_dbg_state (dbg_state)
`ifdef CPU1_MEM_COPIER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  // ---------------- RAM model: registered address, unregistered data ----
  logic [DW-1:0] mem     [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic [AW-1:0] rd_addr;
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (clken) begin
      if (chipselect && write) mem[address] <= writedata;
      rd_addr <= address;
    end
  end
  assign readdata = mem[rd_addr];

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_wa_q[$];
  logic [31:0] exp_wd_q[$];
  logic [31:0] exp_ra_q[$];
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  always @(negedge clk) begin
    if (mon_en && clken && chipselect) begin
      chk("byteenable", 32'(byteenable), 32'hF);
      if (write) begin
        if (exp_wa_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          chk("wr_addr", 32'(address), exp_wa_q.pop_front());
          chk("wr_data", writedata, exp_wd_q.pop_front());
        end
      end else begin
        if (exp_ra_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", 32'(address), exp_ra_q.pop_front());
      end
    end
  end

  // ---------------- driver: one command, reference model up front ----------
  task automatic run_cmd(input bit fill, input int src, input int dst, input int len,
                         input logic [31:0] pat, input int st_at, input int st_n,
                         input bit rnd_st, input int rst_at);
    int clen, nw, base, k, stalls, budget;
    bit seen, cs_seen, st_prev, st_done;
    logic [31:0] d, sum, snap_a, snap_wd;
    logic snap_cs, snap_we;
    clen = (len > DEPTH) ? DEPTH : len;
    nw   = (rst_at > 0) ? rst_at : clen;
    sum  = 0;
    for (int i = 0; i < nw; i++) begin
      int a;
      a = (dst + i) % DEPTH;
      if (fill) d = pat;
      else begin
        d = ref_mem[(src + i) % DEPTH];
        exp_ra_q.push_back((src + i) % DEPTH);
      end
      ref_mem[a] = d;
      exp_wa_q.push_back(a);
      exp_wd_q.push_back(d);
      sum += d;
    end
    base   = fill ? clen + 1 : 2 * clen + 1;
    budget = 2 * base + 40;

    @(posedge clk); #1;
    cmd_fill = fill; cmd_src = AW'(src); cmd_dst = AW'(dst);
    cmd_len = LW'(len); cmd_pattern = pat; cmd_valid = 1'b1;
    @(negedge clk);
    chk("cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    k = 0; stalls = 0; seen = 0; cs_seen = 0; st_prev = 0;
    snap_a = 0; snap_wd = 0; snap_cs = 0; snap_we = 0;
    while (!seen && k < budget) begin
      k++;
      if (st_n > 0) stall = (k >= st_at) && (k < st_at + st_n);
      else if (rnd_st) stall = ($urandom_range(0, 3) == 0);
      else stall = 1'b0;
      if (rst_at > 0 && k == rst_at) reset = 1'b1;
      @(negedge clk);
      if (chipselect) cs_seen = 1;
      if (k == 1) chk("busy", 32'(busy), 1);
      if (stall) begin
        chk("clken", 32'(clken), 0);
        if (st_prev) begin
          chk("frz_addr", 32'(address), snap_a);
          chk("frz_cs", 32'(chipselect), 32'(snap_cs));
          chk("frz_we", 32'(write), 32'(snap_we));
          chk("frz_wd", writedata, snap_wd);
        end else begin
          snap_a = 32'(address); snap_cs = chipselect; snap_we = write; snap_wd = writedata;
        end
      end
      st_prev = stall;
      if (reset) break;
      if (done) seen = 1;
      else if (stall) stalls++;
      if (!seen) begin
        @(posedge clk); #1;
      end
    end
    st_done = stall;

    if (rst_at > 0) begin
      @(posedge clk); #1;
      reset = 1'b0; stall = 1'b0;
      @(negedge clk);
      chk("rst_no_done", 32'(seen), 0);
      chk("rst_ready", 32'(cmd_ready), 1);
      chk("rst_cs", 32'(chipselect), 0);
      chk("rst_busy", 32'(busy), 0);
`ifdef CPU1_MEM_COPIER_CHECKSUM_EN
      chk("rst_checksum", checksum, 0);
`endif
      repeat (4) @(negedge clk);
      chk("rst_writes_left", exp_wa_q.size(), 0);
    end else begin
      chk("done_seen", 32'(seen), 1);
      if (seen) begin
        chk("done_lat", k, base + stalls);
        chk("done_busy", 32'(busy), 1);
`ifdef CPU1_MEM_COPIER_CHECKSUM_EN
        chk("checksum", checksum, sum);
`endif
      end
      @(posedge clk); #1;
      stall = 1'b0;
      @(negedge clk);
      if (!st_done) begin
        chk("ready_after_done", 32'(cmd_ready), 1);
        chk("done_one_cycle", 32'(done), 0);
      end
      for (int w = 0; w < 8 && !cmd_ready; w++) @(negedge clk);
      if (len == 0) chk("len0_no_cs", 32'(cs_seen), 0);
      chk("wr_q_empty", exp_wa_q.size(), 0);
      chk("rd_q_empty", exp_ra_q.size(), 0);
    end
    for (int i = 0; i < nw; i++)
      chk("mem", mem[(dst + i) % DEPTH], ref_mem[(dst + i) % DEPTH]);
    exp_wa_q.delete(); exp_wd_q.delete(); exp_ra_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    // Preload the low window and the top of memory while the DUT is in reset.
    @(posedge clk); #1;
    pl_we = 1'b1;
    for (int i = 0; i < 130; i++) begin
      int a;
      logic [31:0] v;
      a = (i < 128) ? i : DEPTH - 2 + (i - 128);
      v = (i < 3) ? 32'(i + 1) : $urandom;
      pl_addr = AW'(a); pl_data = v; ref_mem[a] = v;
      @(posedge clk); #1;
    end
    pl_we = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy0", 32'(busy), 0);
    chk("rst_done0", 32'(done), 0);
    chk("rst_cs0", 32'(chipselect), 0);
    chk("rst_write0", 32'(write), 0);
    chk("rst_addr0", 32'(address), 0);
    chk("rst_wd0", writedata, 0);
    chk("rst_be0", 32'(byteenable), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
`ifdef CPU1_MEM_COPIER_CHECKSUM_EN
    chk("rst_checksum0", checksum, 0);
`endif
    mon_en = 1'b1;

    run_cmd(1, 0, 'h0100, 4, 32'hDEADBEEF, 0, 0, 0, 0);  // fill
    run_cmd(0, 0, 'h0200, 3, 32'h0, 0, 0, 0, 0);         // copy 1,2,3
    run_cmd(0, 'h7FFE, 'h1000, 4, 32'h0, 0, 0, 0, 0);    // source wrap
    run_cmd(1, 0, 'h7FFD, 5, 32'hA5A55A5A, 0, 0, 0, 0);  // destination wrap
    run_cmd(0, 5, 'h0300, 0, 32'h0, 0, 0, 0, 0);         // zero length
    run_cmd(0, 'h10, 'h0400, 2, 32'h0, 2, 3, 0, 0);      // stall after first RD
    run_cmd(1, 0, 'h0500, 10, 32'h12345678, 0, 0, 0, 3); // reset in third WR
    run_cmd(0, 8, 10, 12, 32'h0, 0, 0, 0, 0);            // overlapping forward copy

    for (int t = 0; t < 16; t++) begin
      run_cmd(bit'($urandom_range(0, 1)), int'($urandom_range(0, 100)),
              int'($urandom_range(0, 100)), int'($urandom_range(0, 20)),
              $urandom, 0, 0, 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
